// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with a synchronised input, false-start
// rejection, a valid/ready output register, and frame/parity/overrun error pulses.
module uart_rx_param #(
  parameter int unsigned Oversample = 16,
  parameter int unsigned DataBits   = 8,
  parameter int unsigned ParityMode = 0,
  parameter int unsigned StopBits   = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                in,
  output logic [DataBits-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                frameErr,
  output logic                parityErr,
  output logic                overrun
);

  localparam int unsigned CntW = $clog2(Oversample);
  localparam int unsigned IdxW = $clog2(DataBits + 1);

  localparam logic [CntW-1:0] CntTop    = CntW'(Oversample - 1);
  localparam logic [CntW-1:0] CntMid    = CntW'(Oversample / 2);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(DataBits);
  localparam logic            StopLast  = 1'(StopBits - 1);
  localparam logic            OddParity = (ParityMode == 2);
  localparam bit              HasParity = (ParityMode != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state;
  state_t              stateNext;
  logic                sync1;
  logic                s;
  logic                sPrev;
  logic [CntW-1:0]     sampleCount;
  logic [IdxW-1:0]     bitIdx;
  logic                stopIdx;
  logic [DataBits-1:0] shiftReg;
  logic                parityBad;
  logic                frameBad;
  logic                midBit;
  logic                bitEnd;
  logic                complete;
  logic                frameBadNow;
  logic                goodFrame;
  logic                consume;

  assign midBit    = (sampleCount == CntMid);
  assign bitEnd    = (sampleCount == '0);
  assign consume   = valid && ready;
  assign goodFrame = complete && !frameBadNow && !parityBad;

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
      sPrev <= 1'b1;
    end else begin
      sync1 <= in;
      s     <= sync1;
      sPrev <= s;
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= stateNext;
  end

  // frameBadNow folds in the final stop sample so completion sees it in the same cycle.
  always_comb begin
    stateNext   = state;
    complete    = 1'b0;
    frameBadNow = frameBad;
    case (state)
      IDLE:   if (!s && sPrev) stateNext = START;
      START: begin
        if (midBit && s)  stateNext = IDLE;
        else if (bitEnd)  stateNext = DATA;
      end
      DATA:   if (bitEnd && bitIdx == IdxLast) stateNext = HasParity ? PARITY : STOP;
      PARITY: if (bitEnd) stateNext = STOP;
      STOP: begin
        if (midBit) begin
          if (!s) frameBadNow = 1'b1;
          if (stopIdx == StopLast) begin
            complete  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sampleCount <= CntTop;
      bitIdx      <= '0;
      stopIdx     <= 1'b0;
      shiftReg    <= '0;
      parityBad   <= 1'b0;
      frameBad    <= 1'b0;
    end else begin
      if (stateNext != state || bitEnd) sampleCount <= CntTop;
      else                              sampleCount <= sampleCount - CntW'(1);
      case (state)
        IDLE, START: begin
          bitIdx    <= '0;
          stopIdx   <= 1'b0;
          parityBad <= 1'b0;
          frameBad  <= 1'b0;
        end
        DATA: begin
          if (midBit) begin
            shiftReg <= {s, shiftReg[DataBits-1:1]};
            bitIdx   <= bitIdx + IdxW'(1);
          end
        end
        PARITY: if (midBit) parityBad <= (s != ((^shiftReg) ^ OddParity));
        STOP: begin
          if (midBit && !s) frameBad <= 1'b1;
          if (bitEnd)       stopIdx  <= stopIdx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      data      <= '0;
      valid     <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frameErr  <= complete && frameBadNow;
      parityErr <= complete && !frameBadNow && parityBad;
      overrun   <= goodFrame && valid && !ready;
      if (goodFrame && (!valid || ready)) begin
        data  <= shiftReg;
        valid <= 1'b1;
      end else if (consume) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three configurations (8N1, 8E1, 8N2) checked cycle by
// cycle against a frame-level event model with a valid/ready holding register.
module tb_uart_rx_param;

  localparam int OS      = 16;
  localparam int KGood   = 0;
  localparam int KFrame  = 1;
  localparam int KParity = 2;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  logic [2:0] lineIn = '1;
  logic [2:0] rdy = '1;
  logic [2:0][7:0] dataOut;
  logic [2:0] validOut;
  logic [2:0] fErr;
  logic [2:0] pErr;
  logic [2:0] ovr;

  always #5 clk = ~clk;

  uart_rx_param #(.Oversample(OS), .DataBits(8), .ParityMode(0), .StopBits(1)) dut8n1 (
    .clk(clk), .nReset(nReset), .in(lineIn[0]), .data(dataOut[0]), .valid(validOut[0]),
    .ready(rdy[0]), .frameErr(fErr[0]), .parityErr(pErr[0]), .overrun(ovr[0]));
  uart_rx_param #(.Oversample(OS), .DataBits(8), .ParityMode(1), .StopBits(1)) dut8e1 (
    .clk(clk), .nReset(nReset), .in(lineIn[1]), .data(dataOut[1]), .valid(validOut[1]),
    .ready(rdy[1]), .frameErr(fErr[1]), .parityErr(pErr[1]), .overrun(ovr[1]));
  uart_rx_param #(.Oversample(OS), .DataBits(8), .ParityMode(0), .StopBits(2)) dut8n2 (
    .clk(clk), .nReset(nReset), .in(lineIn[2]), .data(dataOut[2]), .valid(validOut[2]),
    .ready(rdy[2]), .frameErr(fErr[2]), .parityErr(pErr[2]), .overrun(ovr[2]));

  typedef struct {
    int         dut;
    int         at;
    int         kind;
    logic [7:0] word;
  } ev_t;

  typedef struct {
    int         dut;
    logic [7:0] word;
    bit         badPar;
    logic [1:0] badStop;
    int         rdyMode;
    int         gap;
    int         expKind;
  } vec_t;

  ev_t  evq[$];
  vec_t tbl[10];

  int cyc = 0;
  int nVec = 0;
  int nMis = 0;
  int readyMode[3] = '{1, 1, 1};

  logic [2:0]      mValid = '0;
  logic [2:0]      mF = '0;
  logic [2:0]      mP = '0;
  logic [2:0]      mO = '0;
  logic [2:0][7:0] mData = '0;

  function automatic int parMode(input int k);
    return (k == 1) ? 1 : 0;
  endfunction

  function automatic int stopCnt(input int k);
    return (k == 2) ? 2 : 1;
  endfunction

  function automatic int latency(input int k);
    return 3 + (1 + 8 + ((parMode(k) != 0) ? 1 : 0) + stopCnt(k) - 1) * OS + OS / 2;
  endfunction

  function automatic int modelKind(input int k, input bit badPar, input logic [1:0] badStop);
    if (badStop[0] || (stopCnt(k) == 2 && badStop[1])) return KFrame;
    if (parMode(k) != 0 && badPar) return KParity;
    return KGood;
  endfunction

  // Called at a negedge; returns at a negedge after the stop bits and idle gap.
  task automatic sendFrame(input int k, input logic [7:0] w, input bit badPar,
                           input logic [1:0] badStop, input int kind, input int gap);
    evq.push_back('{k, cyc + latency(k), kind, w});
    lineIn[k] = 1'b0;
    repeat (OS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      lineIn[k] = w[i];
      repeat (OS) @(negedge clk);
    end
    if (parMode(k) != 0) begin
      lineIn[k] = (^w) ^ badPar;
      repeat (OS) @(negedge clk);
    end
    for (int j = 0; j < stopCnt(k); j++) begin
      lineIn[k] = ~badStop[j];
      repeat (OS) @(negedge clk);
    end
    lineIn[k] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: compare at negedge, then advance the model on the following posedge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        nVec++;
        if ({validOut[k], fErr[k], pErr[k], ovr[k], dataOut[k]} !==
            {mValid[k], mF[k], mP[k], mO[k], mData[k]}) begin
          nMis++;
          $display("FAIL dut%0d cyc=%0d valid/frameErr/parityErr/overrun/data got %b/%b/%b/%b/%h required %b/%b/%b/%b/%h",
                   k, cyc, validOut[k], fErr[k], pErr[k], ovr[k], dataOut[k],
                   mValid[k], mF[k], mP[k], mO[k], mData[k]);
        end
        case (readyMode[k])
          0:       rdy[k] = 1'b0;
          1:       rdy[k] = 1'b1;
          default: rdy[k] = 1'($urandom_range(0, 1));
        endcase
      end
      @(posedge clk);
      cyc++;
      for (int k = 0; k < 3; k++) begin
        bit cons;
        bit load;
        logic [7:0] w;
        mF[k] = 1'b0;
        mP[k] = 1'b0;
        mO[k] = 1'b0;
        load  = 1'b0;
        w     = '0;
        cons  = mValid[k] && rdy[k];
        if (!nReset) begin
          mValid[k] = 1'b0;
          mData[k]  = '0;
          for (int i = evq.size() - 1; i >= 0; i--)
            if (evq[i].dut == k) evq.delete(i);
        end else begin
          for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].dut == k && evq[i].at == cyc) begin
              if (evq[i].kind == KFrame)       mF[k] = 1'b1;
              else if (evq[i].kind == KParity) mP[k] = 1'b1;
              else if (!mValid[k] || cons) begin
                load = 1'b1;
                w    = evq[i].word;
              end else mO[k] = 1'b1;
              evq.delete(i);
            end
          end
          if (load) begin
            mValid[k] = 1'b1;
            mData[k]  = w;
          end else if (cons) begin
            mValid[k] = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    tbl[0] = '{0, 8'hA5, 1'b0, 2'b00, 1, 20, KGood};
    tbl[1] = '{1, 8'h96, 1'b0, 2'b00, 1, 20, KGood};
    tbl[2] = '{1, 8'h3C, 1'b1, 2'b00, 1, 20, KParity};
    tbl[3] = '{2, 8'h55, 1'b0, 2'b10, 1, 20, KFrame};
    tbl[4] = '{2, 8'h0F, 1'b0, 2'b00, 1, 20, KGood};
    tbl[5] = '{2, 8'h00, 1'b0, 2'b01, 2, 20, KFrame};
    tbl[6] = '{1, 8'hFF, 1'b1, 2'b01, 2, 20, KFrame};
    tbl[7] = '{0, 8'h00, 1'b0, 2'b00, 2, 20, KGood};
    tbl[8] = '{0, 8'hC3, 1'b0, 2'b01, 1, 20, KFrame};
    tbl[9] = '{1, 8'h01, 1'b0, 2'b00, 0, 20, KGood};

    repeat (3) @(negedge clk);
    #1 nReset = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 10; t++) begin
      readyMode[tbl[t].dut] = tbl[t].rdyMode;
      sendFrame(tbl[t].dut, tbl[t].word, tbl[t].badPar, tbl[t].badStop, tbl[t].expKind, tbl[t].gap);
    end

    // Back-to-back frames with the consumer stalled: second one overruns.
    readyMode[0] = 0;
    sendFrame(0, 8'h11, 1'b0, 2'b00, KGood, 0);
    sendFrame(0, 8'h22, 1'b0, 2'b00, KGood, 40);
    readyMode[0] = 1;
    repeat (5) @(negedge clk);

    // Short low glitch is rejected as a false start.
    lineIn[0] = 1'b0;
    repeat (4) @(negedge clk);
    lineIn[0] = 1'b1;
    repeat (20) @(negedge clk);
    sendFrame(0, 8'h81, 1'b0, 2'b00, KGood, 30);

    // Reset in the middle of the data bits aborts the frame.
    fork
      sendFrame(0, 8'hFF, 1'b0, 2'b00, KGood, 10);
      begin
        repeat (60) @(negedge clk);
        #1 nReset = 1'b0;
        repeat (5) @(negedge clk);
        #1 nReset = 1'b1;
      end
    join
    sendFrame(0, 8'h42, 1'b0, 2'b00, KGood, 30);

    for (int n = 0; n < 40; n++) begin
      int k;
      int gap;
      bit bp;
      logic [1:0] bs;
      logic [7:0] w;
      k   = $urandom_range(0, 2);
      w   = 8'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      gap = $urandom_range(0, 12);
      if (bs != 2'b00) gap = gap + 4;
      readyMode[k] = $urandom_range(0, 2);
      sendFrame(k, w, bp, bs, modelKind(k, bp, bs), gap);
    end

    readyMode[0] = 1;
    readyMode[1] = 1;
    readyMode[2] = 1;
    repeat (50) @(negedge clk);
    nVec++;
    if (evq.size() != 0) begin
      nMis++;
      $display("FAIL pendingEvents got %0d required 0", evq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
